// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: hold-bus encoding, sequencer
// state encoding and the all-zero data word.
package pipe_ctrl_pkg;

    localparam int unsigned HoldFlagBus = 3;
    localparam int unsigned DrainW      = 4;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;

    // Hold levels: a held pipe register loads its NOP/zero default; pc_reg freezes.
    typedef enum logic [HoldFlagBus-1:0] {
        HoldNone = 3'd0,
        HoldPc   = 3'd1,
        HoldIf   = 3'd2,
        HoldId   = 3'd3
    } hold_e;

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StMcWait = 2'd1,
        StDrain  = 2'd2,
        StGrant  = 2'd3
    } state_e;

endpackage

// File: rtl/pipe_ctrl.sv
// Central pipeline sequencer for the 3-stage core.
//
// Ports:
//   clk, rst           - clock, asynchronous active-high reset
//   jump_req_i/addr_i  - taken branch/jump resolved in EX
//   load_use_i         - ID depends on a load in EX; replay from id_inst_addr_i
//   mc_start_i         - EX launches a multi-cycle op; resume at mc_resume_addr_i
//   mc_done_i          - multi-cycle result ready (pulse)
//   bus_req_i          - external master requests the bus (level)
//   hold_flag_o        - shared hold bus to pc_reg / if_id / id_ex
//   jump_flag_o/addr_o - PC redirect request and target
//   bus_grant_o        - bus owned by the external master
//   stall_cnt_o        - count of cycles with a non-zero hold (wraps)
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             jump_req_i,
    input  logic [31:0]      jump_addr_i,
    input  logic             load_use_i,
    input  logic [31:0]      id_inst_addr_i,
    input  logic             mc_start_i,
    input  logic [31:0]      mc_resume_addr_i,
    input  logic             mc_done_i,
    input  logic             bus_req_i,
    output logic [2:0]       hold_flag_o,
    output logic             jump_flag_o,
    output logic [31:0]      jump_addr_o,
    output logic             bus_grant_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    // Counter value is the number of Hold_If cycles still owed after the
    // current one, so the RUN cycle that accepts bus_req_i counts as the first.
    localparam logic [DrainW-1:0] DrainLoad = DrainW'(DRAIN_CYCLES - 1);

    state_e             state_q, state_d;
    logic [DrainW-1:0]  drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0]   stall_cnt_q;
    hold_e              hold;

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        hold        = HoldNone;
        jump_flag_o = 1'b0;
        jump_addr_o = ZeroWord;
        bus_grant_o = 1'b0;

        unique case (state_q)
            // DRAIN shares RUN's redirect priority so any redirect aborts it;
            // a still-high bus_req_i is re-arbitrated from RUN afterwards.
            StRun, StDrain: begin
                if (jump_req_i) begin
                    jump_flag_o = 1'b1;
                    jump_addr_o = jump_addr_i;
                    hold        = HoldId;
                    state_d     = StRun;
                end else if (mc_start_i) begin
                    jump_flag_o = 1'b1;
                    jump_addr_o = mc_resume_addr_i;
                    hold        = HoldId;
                    state_d     = StMcWait;
                end else if (load_use_i) begin
                    jump_flag_o = 1'b1;
                    jump_addr_o = id_inst_addr_i;
                    hold        = HoldId;
                    state_d     = StRun;
                end else if (state_q == StRun) begin
                    if (bus_req_i) begin
                        hold        = HoldIf;
                        drain_cnt_d = DrainLoad;
                        state_d     = (DrainLoad == '0) ? StGrant : StDrain;
                    end
                end else begin
                    // Hold stays applied this cycle even if the request drops.
                    hold = HoldIf;
                    if (!bus_req_i) begin
                        state_d = StRun;
                    end else begin
                        drain_cnt_d = (drain_cnt_q == '0) ? '0 : drain_cnt_q - 1'b1;
                        if (drain_cnt_q <= DrainW'(1)) begin
                            state_d = StGrant;
                        end
                    end
                end
            end
            StMcWait: begin
                if (mc_done_i) begin
                    state_d = StRun;
                end else begin
                    hold = HoldId;
                end
            end
            StGrant: begin
                // PC was frozen throughout, so release needs no replay.
                if (bus_req_i) begin
                    bus_grant_o = 1'b1;
                    hold        = HoldIf;
                end else begin
                    state_d = StRun;
                end
            end
            default: begin
                state_d = StRun;
            end
        endcase

        // Outputs are forced quiet for the whole reset interval.
        if (rst) begin
            hold        = HoldNone;
            jump_flag_o = 1'b0;
            jump_addr_o = ZeroWord;
            bus_grant_o = 1'b0;
        end
    end

    assign hold_flag_o = hold;
    assign stall_cnt_o = stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StRun;
            drain_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            if (hold != HoldNone) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

endmodule
